// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Definitions shared by the AXI-Lite register slave and the interconnect
// address decoder.
//   axil_resp_t : AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   wr_state_t  : write channel FSM states (W_IDLE, W_RESP)
//   rd_state_t  : read channel FSM states (R_IDLE, R_DATA)
//   AXIL_DATA_WIDTH : the only supported AXI-Lite data width
// -----------------------------------------------------------------------------
package axil_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// -----------------------------------------------------------------------------
// axil_reg_bank
// Storage for NUM_REGS 32-bit registers with byte-strobe write merge, a
// combinational read mux and a flattened view of all registers.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears all registers)
//   wr_en      : commit wr_data into register wr_idx, byte lanes per wr_strb
//   wr_idx     : register index for the write
//   wr_data    : write data
//   wr_strb    : byte lane enables
//   rd_idx     : register index for the read mux
//   rd_data    : contents of register rd_idx (0 when rd_idx >= NUM_REGS)
//   regs_o     : all registers, reg i at bits [32i+31:32i]
// -----------------------------------------------------------------------------
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [AXIL_DATA_WIDTH-1:0]          wr_data,
  input  logic [AXIL_STRB_WIDTH-1:0]          wr_strb,
  input  logic [IDX_W-1:0]                    rd_idx,
  output logic [AXIL_DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*AXIL_DATA_WIDTH-1:0] regs_o
);

  logic [AXIL_DATA_WIDTH-1:0] w_regs [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
    logic [AXIL_DATA_WIDTH-1:0] r_q;
    logic                       w_sel;

    // Full-width index compare, so an out-of-range index never aliases.
    assign w_sel = wr_en && (wr_idx == IDX_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_sel) begin
        for (int b = 0; b < AXIL_STRB_WIDTH; b++) begin
          if (wr_strb[b]) begin
            r_q[8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end

    assign w_regs[gi] = r_q;
    assign regs_o[gi*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH] = r_q;
  end

  // Compare-and-select mux: indices at or beyond NUM_REGS read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = w_regs[i];
      end
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// -----------------------------------------------------------------------------
// axil_reg_slave
// AXI-Lite responder for one decoded slave window, backed by NUM_REGS 32-bit
// read/write registers. Write (AW/W/B) and read (AR/R) channels run as two
// independent FSMs. All channel outputs are registered.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*                   : AXI-Lite write address/data/response
//   s_ar*/s_r*                        : AXI-Lite read address/data
//   regs_o                            : register contents, reg i at [32i+31:32i]
// Build option:
//   AXIL_REG_SLVERR_EN : when defined, out-of-range accesses answer SLVERR;
//                        otherwise they answer OKAY (writes dropped, reads 0).
// -----------------------------------------------------------------------------
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,   // only 32 is supported
  parameter int NUM_REGS    = 8,    // 1..1024
  parameter int WINDOW_SIZE = 4096  // power of two, >= 4*NUM_REGS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int OFF_W = $clog2(WINDOW_SIZE);
  localparam int IDX_W = (OFF_W > 2) ? OFF_W - 2 : 1;

  // Address decode: offset within the window, word index, range check.
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_ar_in_range;
  logic             w_wr_in_range;
  logic             w_unused;

  assign w_aw_idx = IDX_W'(s_awaddr[OFF_W-1:0] >> 2);
  assign w_ar_idx = IDX_W'(s_araddr[OFF_W-1:0] >> 2);

  // Address bits outside the window offset are ignored by design.
  assign w_unused = ^{s_awaddr, s_araddr};

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  wr_state_t        r_wstate, r_wstate_next;
  logic             r_awready, r_awready_next;
  logic             r_wready, r_wready_next;
  logic             r_aw_held, r_aw_held_next;
  logic             r_w_held, r_w_held_next;
  logic [IDX_W-1:0] r_awidx, r_awidx_next;
  logic [DATA_WIDTH-1:0]   r_wdata, r_wdata_next;
  logic [DATA_WIDTH/8-1:0] r_wstrb, r_wstrb_next;
  logic             r_bvalid, r_bvalid_next;
  axil_resp_t       r_bresp, r_bresp_next;
  logic             w_commit;
  axil_resp_t       w_wr_resp;

  assign w_wr_in_range = 32'(r_awidx) < 32'(NUM_REGS);

`ifdef AXIL_REG_SLVERR_EN
  assign w_wr_resp = w_wr_in_range ? OKAY : SLVERR;
`else
  assign w_wr_resp = OKAY;
`endif

  always_comb begin
    r_wstate_next  = r_wstate;
    r_awready_next = r_awready;
    r_wready_next  = r_wready;
    r_aw_held_next = r_aw_held;
    r_w_held_next  = r_w_held;
    r_awidx_next   = r_awidx;
    r_wdata_next   = r_wdata;
    r_wstrb_next   = r_wstrb;
    r_bvalid_next  = r_bvalid;
    r_bresp_next   = r_bresp;
    w_commit       = 1'b0;

    case (r_wstate)
      W_IDLE: begin
        if (r_aw_held && r_w_held) begin
          // Both halves captured: commit this edge and answer next cycle.
          w_commit       = 1'b1;
          r_wstate_next  = W_RESP;
          r_bvalid_next  = 1'b1;
          r_bresp_next   = w_wr_resp;
          r_aw_held_next = 1'b0;
          r_w_held_next  = 1'b0;
        end else begin
          if (!r_aw_held) begin
            if (s_awvalid && r_awready) begin
              r_aw_held_next = 1'b1;
              r_awidx_next   = w_aw_idx;
              r_awready_next = 1'b0;
            end else begin
              // Also covers the first cycle out of reset.
              r_awready_next = 1'b1;
            end
          end
          if (!r_w_held) begin
            if (s_wvalid && r_wready) begin
              r_w_held_next = 1'b1;
              r_wdata_next  = s_wdata;
              r_wstrb_next  = s_wstrb;
              r_wready_next = 1'b0;
            end else begin
              r_wready_next = 1'b1;
            end
          end
        end
      end
      W_RESP: begin
        if (s_bready) begin
          r_wstate_next  = W_IDLE;
          r_bvalid_next  = 1'b0;
          r_awready_next = 1'b1;
          r_wready_next  = 1'b1;
        end
      end
      default: r_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      r_wstate  <= r_wstate_next;
      r_awready <= r_awready_next;
      r_wready  <= r_wready_next;
      r_aw_held <= r_aw_held_next;
      r_w_held  <= r_w_held_next;
      r_awidx   <= r_awidx_next;
      r_wdata   <= r_wdata_next;
      r_wstrb   <= r_wstrb_next;
      r_bvalid  <= r_bvalid_next;
      r_bresp   <= r_bresp_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  rd_state_t             r_rstate, r_rstate_next;
  logic                  r_arready, r_arready_next;
  logic                  r_rvalid, r_rvalid_next;
  logic [DATA_WIDTH-1:0] r_rdata, r_rdata_next;
  axil_resp_t            r_rresp, r_rresp_next;
  logic [DATA_WIDTH-1:0] w_bank_rdata;
  axil_resp_t            w_rd_resp;

  assign w_ar_in_range = 32'(w_ar_idx) < 32'(NUM_REGS);

`ifdef AXIL_REG_SLVERR_EN
  assign w_rd_resp = w_ar_in_range ? OKAY : SLVERR;
`else
  assign w_rd_resp = OKAY;
`endif

  always_comb begin
    r_rstate_next  = r_rstate;
    r_arready_next = r_arready;
    r_rvalid_next  = r_rvalid;
    r_rdata_next   = r_rdata;
    r_rresp_next   = r_rresp;

    case (r_rstate)
      R_IDLE: begin
        if (s_arvalid && r_arready) begin
          // Bank contents sampled before any write committing on this edge.
          r_rstate_next  = R_DATA;
          r_arready_next = 1'b0;
          r_rvalid_next  = 1'b1;
          r_rdata_next   = w_ar_in_range ? w_bank_rdata : '0;
          r_rresp_next   = w_rd_resp;
        end else begin
          r_arready_next = 1'b1;
        end
      end
      R_DATA: begin
        if (s_rready) begin
          r_rstate_next  = R_IDLE;
          r_rvalid_next  = 1'b0;
          r_arready_next = 1'b1;
        end
      end
      default: r_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      r_rstate  <= r_rstate_next;
      r_arready <= r_arready_next;
      r_rvalid  <= r_rvalid_next;
      r_rdata   <= r_rdata_next;
      r_rresp   <= r_rresp_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_commit && w_wr_in_range),
    .wr_idx  (r_awidx),
    .wr_data (r_wdata),
    .wr_strb (r_wstrb),
    .rd_idx  (w_ar_idx),
    .rd_data (w_bank_rdata),
    .regs_o  (regs_o)
  );

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

endmodule

// File: tb/tb_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_reg_slave
// Directed, table-driven bench for axil_reg_slave (NUM_REGS=8,
// WINDOW_SIZE=4096) plus hand-written sequences for write-before-address,
// back-pressure hold, same-edge read/commit and reset during W_RESP.
// Expected out-of-range response follows AXIL_REG_SLVERR_EN.
// -----------------------------------------------------------------------------
module tb_axil_reg_slave;

  localparam int NR = 8;

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]    s_wstrb;
  logic          s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]    s_bresp, s_rresp;
  logic          s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NR*32-1:0] regs_o;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  axil_reg_slave #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .NUM_REGS    (NR),
    .WINDOW_SIZE (4096)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .regs_o    (regs_o)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;      // write data
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_val;   // read: rdata; write: register value afterwards
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_at(input int idx);
    return regs_o[idx*32 +: 32];
  endfunction

  // AW and W presented together, bready held high.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp,
                          input logic [31:0] exp_reg);
    int idx;
    idx = int'(addr % 4096) / 4;
    check("awready_idle", s_awready, 1);
    check("wready_idle", s_wready, 1);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1; s_wvalid = 1; s_bready = 1;
    tick();                                   // AW/W handshake edge
    s_awvalid = 0; s_wvalid = 0;
    check("awready_drop", s_awready, 0);
    check("bvalid_early", s_bvalid, 0);
    tick();                                   // commit edge
    check("bvalid", s_bvalid, 1);
    check("bresp", s_bresp, exp_resp);
    if (idx < NR) check("regs_o_wr", reg_at(idx), exp_reg);
    tick();                                   // B handshake edge
    check("bvalid_clr", s_bvalid, 0);
    check("awready_back", s_awready, 1);
    $display("WR addr=0x%08h data=0x%08h strb=0x%h bresp=%0d", addr, data, strb, exp_resp);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    check("arready_idle", s_arready, 1);
    s_araddr = addr; s_arvalid = 1; s_rready = 1;
    tick();                                   // AR handshake edge
    s_arvalid = 0;
    check("rvalid", s_rvalid, 1);
    check("arready_drop", s_arready, 0);
    data = s_rdata;
    resp = s_rresp;
    tick();                                   // R handshake edge
    check("rvalid_clr", s_rvalid, 0);
    check("arready_back", s_arready, 1);
    $display("RD addr=0x%08h rdata=0x%08h rresp=%0d", addr, data, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [31:0] exp_final [NR];

    vecs[0]  = '{1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00,    32'hDEAD_BEEF};
    vecs[1]  = '{0, 32'h0000_0004, 32'h0,          4'h0, 2'b00,    32'hDEAD_BEEF};
    vecs[2]  = '{1, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 2'b00,    32'hFFFF_FFFF};
    vecs[3]  = '{1, 32'h0000_000C, 32'h0000_00AA, 4'h1, 2'b00,    32'hFFFF_FFAA};
    vecs[4]  = '{0, 32'h0000_000C, 32'h0,          4'h0, 2'b00,    32'hFFFF_FFAA};
    vecs[5]  = '{1, 32'h0000_001C, 32'h1122_3344, 4'hA, 2'b00,    32'h1100_3300};
    vecs[6]  = '{0, 32'h0000_001C, 32'h0,          4'h0, 2'b00,    32'h1100_3300};
    vecs[7]  = '{1, 32'h0000_001C, 32'hFFFF_FFFF, 4'h0, 2'b00,    32'h1100_3300};
    vecs[8]  = '{0, 32'h0000_001F, 32'h0,          4'h0, 2'b00,    32'h1100_3300};
    vecs[9]  = '{1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, OOR_RESP, 32'h0};
    vecs[10] = '{0, 32'h0000_0020, 32'h0,          4'h0, OOR_RESP, 32'h0};
    vecs[11] = '{0, 32'h0000_1004, 32'h0,          4'h0, 2'b00,    32'hDEAD_BEEF};
    vecs[12] = '{1, 32'h0000_1010, 32'h55AA_55AA, 4'hF, 2'b00,    32'h55AA_55AA};
    vecs[13] = '{0, 32'h0000_0010, 32'h0,          4'h0, 2'b00,    32'h55AA_55AA};
    vecs[14] = '{0, 32'h0000_0000, 32'h0,          4'h0, 2'b00,    32'h0};

    exp_final = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFAA,
                  32'h55AA_55AA, 32'h0, 32'h0, 32'h1100_3300};

    rst = 1;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
    s_bready = 0; s_araddr = 0; s_arvalid = 0; s_rready = 0;

    // Reset state
    tick(); tick();
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_bresp", s_bresp, 0);
    check("rst_rresp", s_rresp, 0);
    check("rst_rdata", s_rdata, 0);
    for (int i = 0; i < NR; i++) check("rst_reg", reg_at(i), 0);
    rst = 0;
    tick();
    check("ready_after_rst_aw", s_awready, 1);
    check("ready_after_rst_w", s_wready, 1);
    check("ready_after_rst_ar", s_arready, 1);

    // Table-driven vectors
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].wr) begin
        do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].exp_resp, vecs[v].exp_val);
      end else begin
        do_read(vecs[v].addr, rd, rr);
        check("vec_rdata", rd, vecs[v].exp_val);
        check("vec_rresp", rr, vecs[v].exp_resp);
      end
    end
    for (int i = 0; i < NR; i++) check("table_final_reg", reg_at(i), exp_final[i]);

    // W arrives three cycles before AW
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 1;
    s_awaddr = 32'h0000_0008;
    tick();
    s_wvalid = 0;
    check("wfirst_wready_drop", s_wready, 0);
    check("wfirst_awready", s_awready, 1);
    tick(); tick();
    check("wfirst_no_bvalid", s_bvalid, 0);
    check("wfirst_reg2_old", reg_at(2), 0);
    s_awvalid = 1;
    tick();
    s_awvalid = 0;
    check("wfirst_bvalid_early", s_bvalid, 0);
    check("wfirst_reg2_pre", reg_at(2), 0);
    tick();
    check("wfirst_bvalid", s_bvalid, 1);
    check("wfirst_reg2", reg_at(2), 32'h1234_5678);
    tick();
    check("wfirst_bvalid_clr", s_bvalid, 0);
    check("wfirst_wready_back", s_wready, 1);
    $display("WR-wfirst addr=0x00000008 data=0x12345678 reg2=0x%08h", reg_at(2));

    // Back-pressure on B and R; AR handshake on the commit edge reads old value
    s_awaddr = 32'h0000_0018; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; s_bready = 0; s_rready = 0;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    s_araddr = 32'h0000_0018; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    check("hold_reg6_new", reg_at(6), 32'h0BAD_F00D);
    for (int c = 0; c < 5; c++) begin
      check("hold_bvalid", s_bvalid, 1);
      check("hold_bresp", s_bresp, 0);
      check("hold_rvalid", s_rvalid, 1);
      check("hold_rdata_prewrite", s_rdata, 0);
      check("hold_rresp", s_rresp, 0);
      check("hold_awready", s_awready, 0);
      check("hold_wready", s_wready, 0);
      check("hold_arready", s_arready, 0);
      tick();
    end
    s_bready = 1; s_rready = 1;
    tick();
    check("release_bvalid", s_bvalid, 0);
    check("release_rvalid", s_rvalid, 0);
    check("release_awready", s_awready, 1);
    check("release_wready", s_wready, 1);
    check("release_arready", s_arready, 1);
    $display("HOLD wr 0x18 + rd 0x18 released after 5 cycles");
    do_read(32'h0000_0018, rd, rr);
    check("reg6_readback", rd, 32'h0BAD_F00D);

    // Reset while in W_RESP
    s_awaddr = 32'h0; s_wdata = 32'h7777_7777; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; s_bready = 0;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    check("wresp_bvalid", s_bvalid, 1);
    check("wresp_reg0", reg_at(0), 32'h7777_7777);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_bvalid", s_bvalid, 0);
    check("mid_rst_awready", s_awready, 0);
    check("mid_rst_wready", s_wready, 0);
    check("mid_rst_arready", s_arready, 0);
    for (int i = 0; i < NR; i++) check("mid_rst_reg", reg_at(i), 0);
    tick();
    check("post_rst_awready", s_awready, 1);
    check("post_rst_wready", s_wready, 1);
    check("post_rst_arready", s_arready, 1);
    check("post_rst_bvalid", s_bvalid, 0);
    $display("RST in W_RESP: bvalid dropped, registers cleared");
    s_bready = 1;
    do_read(32'h0000_0004, rd, rr);
    check("post_rst_read", rd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
